// File: rtl/alu_mult_sequencer.sv
// Element-serial 5x5 signed matrix multiply sequencer: one dot-product slice, one C element per clock.
// Optional build macro ALU_MULT_SATURATE_EN clamps each element to the signed DW range instead of wrapping.
module alu_mult_sequencer #(
  parameter int DIM   = 5,
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DIM*DIM*DW-1:0]   A_flat,
  input  logic [DIM*DIM*DW-1:0]   B_flat,
  output logic                    busy,
  output logic                    done,
  output logic [DIM*DIM*DW-1:0]   C_flat,
  output logic                    overflow_flag,
  output logic [4:0]              elem_idx
);

  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int MW = DIM * DIM * DW;
  localparam logic [CW-1:0] LAST = CW'(DIM - 1);
  localparam logic signed [ACC_W-1:0] ELEM_MAX = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ELEM_MIN = ~ELEM_MAX;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [MW-1:0]  r_a;
  logic [MW-1:0]  r_b;
  logic [MW-1:0]  r_c;
  logic           r_ovf;
  logic [CW-1:0]  r_i;
  logic [CW-1:0]  r_j;

  logic signed [DW-1:0]    w_a_el [DIM];
  logic signed [DW-1:0]    w_b_el [DIM];
  logic signed [2*DW-1:0]  w_prod [DIM];
  logic signed [ACC_W-1:0] w_acc;
  logic [DW-1:0]           w_elem;
  logic                    w_elem_ovf;
  logic                    w_accept;
  logic                    w_last;

  // Row i of A against column j of B
  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_slice
      assign w_a_el[gi] = r_a[(int'(r_i) * DIM + gi) * DW +: DW];
      assign w_b_el[gi] = r_b[(gi * DIM + int'(r_j)) * DW +: DW];
      assign w_prod[gi] = w_a_el[gi] * w_b_el[gi];
    end
  endgenerate

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < DIM; k++) begin
      w_acc = w_acc + ACC_W'(w_prod[k]);
    end
  end

  assign w_elem_ovf = (w_acc > ELEM_MAX) || (w_acc < ELEM_MIN);

`ifdef ALU_MULT_SATURATE_EN
  always_comb begin
    w_elem = w_acc[DW-1:0];
    if (w_acc > ELEM_MAX) begin
      w_elem = ELEM_MAX[DW-1:0];
    end else if (w_acc < ELEM_MIN) begin
      w_elem = ELEM_MIN[DW-1:0];
    end
  end
`else
  assign w_elem = w_acc[DW-1:0];
`endif

  assign w_accept = (r_state == S_IDLE) && start && !abort;
  assign w_last   = (r_i == LAST) && (r_j == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = S_COMPUTE;
      S_COMPUTE: begin
        if (abort) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // The element is still written on the abort edge; only the state returns to idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (w_accept) begin
      r_a   <= A_flat;
      r_b   <= B_flat;
      r_ovf <= 1'b0;
      r_i   <= '0;
      r_j   <= '0;
    end else if (r_state == S_COMPUTE) begin
      r_c[(int'(r_i) * DIM + int'(r_j)) * DW +: DW] <= w_elem;
      r_ovf <= r_ovf | w_elem_ovf;
      if (w_last) begin
        r_i <= '0;
        r_j <= '0;
      end else if (r_j == LAST) begin
        r_j <= '0;
        r_i <= r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end
  end

  assign busy          = (r_state == S_COMPUTE);
  assign done          = (r_state == S_DONE);
  assign C_flat        = r_c;
  assign overflow_flag = r_ovf;
  assign elem_idx      = (r_state == S_COMPUTE) ? 5'(int'(r_i) * DIM + int'(r_j)) : 5'd0;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: directed and random matrices against a plain-arithmetic matrix-product model.
module tb_alu_mult_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [199:0] A_flat;
  logic [199:0] B_flat;
  logic         busy;
  logic         done;
  logic [199:0] C_flat;
  logic         overflow_flag;
  logic [4:0]   elem_idx;

  int n_total = 0;
  int n_fail  = 0;

  int         ma [5][5];
  int         mb [5][5];
  logic [7:0] exp_c [25];
  logic       exp_ovf;

  always #5 clk = ~clk;

  alu_mult_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .A_flat        (A_flat),
    .B_flat        (B_flat),
    .busy          (busy),
    .done          (done),
    .C_flat        (C_flat),
    .overflow_flag (overflow_flag),
    .elem_idx      (elem_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
    n_total++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [199:0] exp_c_flat();
    logic [199:0] v;
    for (int e = 0; e < 25; e++) v[e*8 +: 8] = exp_c[e];
    return v;
  endfunction

  task automatic drive_operands();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        A_flat[(r*5+c)*8 +: 8] = 8'(ma[r][c]);
        B_flat[(r*5+c)*8 +: 8] = 8'(mb[r][c]);
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        ma[r][c] = int'($urandom_range(255, 0)) - 128;
        mb[r][c] = int'($urandom_range(255, 0)) - 128;
      end
  endtask

  task automatic fill_const(input int va, input int vb);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        ma[r][c] = va;
        mb[r][c] = vb;
      end
  endtask

  // One operation; the *_at arguments inject start/abort/reset at that element index (-1 = never)
  task automatic run_op(input string name, input int abort_at, input int reset_at, input int repulse_at);
    logic [7:0] mv [25];
    logic       mo [25];
    int         acc;
    for (int e = 0; e < 25; e++) begin
      acc = 0;
      for (int k = 0; k < 5; k++) acc += ma[e/5][k] * mb[k][e%5];
      mo[e] = (acc > 127) || (acc < -128);
`ifdef ALU_MULT_SATURATE_EN
      mv[e] = (acc > 127) ? 8'h7F : (acc < -128) ? 8'h80 : 8'(acc);
`else
      mv[e] = 8'(acc);
`endif
    end
    drive_operands();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_ovf = 1'b0;
    for (int e = 0; e < 25; e++) begin
      A_flat[e*8 +: 8] = 8'($urandom);
      B_flat[e*8 +: 8] = 8'($urandom);
    end
    for (int n = 0; n < 25; n++) begin
      chk({name, "_seq"}, {busy, done, elem_idx}, {1'b1, 1'b0, 5'(n)});
      if (n == repulse_at) start = 1'b1;
      if (n == abort_at)   abort = 1'b1;
      if (n == reset_at)   rst_n = 1'b0;
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (n == reset_at) begin
        rst_n = 1'b1;
        for (int e = 0; e < 25; e++) exp_c[e] = 8'h00;
        exp_ovf = 1'b0;
        chk({name, "_rst_ctl"}, {busy, done, overflow_flag, elem_idx}, '0);
        chk({name, "_rst_c"}, C_flat, '0);
        return;
      end
      exp_c[n] = mv[n];
      exp_ovf  = exp_ovf | mo[n];
      if (n == abort_at) begin
        chk({name, "_abort_ctl"}, {busy, done, elem_idx}, '0);
        for (int w = 0; w < 16; w++) begin
          tick();
          chk({name, "_abort_nodone"}, {busy, done}, '0);
        end
        chk({name, "_abort_c"}, C_flat, exp_c_flat());
        chk({name, "_abort_ovf"}, overflow_flag, exp_ovf);
        return;
      end
    end
    chk({name, "_done_ctl"}, {busy, done, elem_idx}, 7'b0100000);
    chk({name, "_c"}, C_flat, exp_c_flat());
    chk({name, "_ovf"}, overflow_flag, exp_ovf);
    tick();
    chk({name, "_idle_ctl"}, {busy, done, elem_idx}, '0);
    chk({name, "_hold_c"}, C_flat, exp_c_flat());
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    A_flat = '0;
    B_flat = '0;
    repeat (3) tick();
    chk("reset_ctl", {busy, done, overflow_flag, elem_idx}, '0);
    chk("reset_c", C_flat, '0);
    for (int e = 0; e < 25; e++) exp_c[e] = 8'h00;
    exp_ovf = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r * 5 + c;
      end
    run_op("identity", -1, -1, -1);

    fill_const(2, 3);
    run_op("twos_threes", -1, -1, -1);
    fill_const(127, 127);
    run_op("max_max", -1, -1, -1);
    fill_const(-128, 127);
    run_op("min_max", -1, -1, -1);
    fill_const(-128, -128);
    run_op("min_min", -1, -1, -1);

    // abort together with start in idle drops the start
    fill_random();
    drive_operands();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_start", {busy, done, elem_idx}, '0);
    tick();
    chk("idle_abort_hold", {busy, done, elem_idx}, '0);
    chk("idle_abort_c", C_flat, exp_c_flat());

    fill_random();
    run_op("repulse", -1, -1, 7);
    fill_random();
    run_op("abort", 10, -1, -1);
    fill_random();
    run_op("midreset", -1, 12, -1);
    fill_random();
    run_op("after_reset", -1, -1, -1);
    for (int t = 0; t < 4; t++) begin
      fill_random();
      run_op("random", -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
